// File: rtl/fpu_issue_sched_pkg.sv
// Shared opcodes, latency defaults and latency-class helpers for the float issue scheduler.
package fpu_issue_sched_pkg;

    localparam int MAX_LAT_DEF  = 8;
    localparam int LAT_ADD_DEF  = 2;
    localparam int LAT_MUL_DEF  = 2;
    localparam int LAT_DIV_DEF  = 4;
    localparam int LAT_SQRT_DEF = 4;
    localparam int LAT_SIMPLE   = 1;

    typedef enum logic [3:0] {
        FLOAT_NONE  = 4'd0,
        FLOAT_FADD  = 4'd1,
        FLOAT_FSUB  = 4'd2,
        FLOAT_FMUL  = 4'd3,
        FLOAT_FDIV  = 4'd4,
        FLOAT_FSQRT = 4'd5,
        FLOAT_ITOF  = 4'd6,
        FLOAT_FLOOR = 4'd7,
        FLOAT_FNEG  = 4'd8,
        FLOAT_FABS  = 4'd9,
        FLOAT_FSLWI = 4'd10
    } float_op_e;

    function automatic int op_latency(input logic [3:0] op, input int lat_add,
                                      input int lat_mul, input int lat_div,
                                      input int lat_sqrt);
        case (op)
            FLOAT_FADD, FLOAT_FSUB, FLOAT_ITOF, FLOAT_FLOOR: return lat_add;
            FLOAT_FMUL:  return lat_mul;
            FLOAT_FDIV:  return lat_div;
            FLOAT_FSQRT: return lat_sqrt;
            default:     return LAT_SIMPLE;
        endcase
    endfunction

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == FLOAT_FDIV) || (op == FLOAT_FSQRT);
    endfunction

endpackage

// File: rtl/fpu_issue_sched_wb_resv.sv
// Writeback reservation shift vector: one bit per future cycle plus the rd/op
// that will retire in that cycle. Slot 0 is the current writeback.
module fpu_wb_resv #(
    parameter int MAX_LAT = 8,
    localparam int IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               set_en,
    input  logic [IW-1:0]      set_idx,
    input  logic [4:0]         set_rd,
    input  logic [3:0]         set_op,
    output logic [MAX_LAT-1:0] slot_busy,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [3:0]         wb_op
);

    logic [MAX_LAT-1:0]       resv_q, resv_d;
    logic [MAX_LAT-1:0][4:0]  rd_q, rd_d;
    logic [MAX_LAT-1:0][3:0]  op_q, op_d;

    // slot_busy is the shifted view, i.e. what each slot will hold next cycle
    assign slot_busy = resv_q >> 1;

    always_comb begin
        resv_d = resv_q >> 1;
        rd_d   = rd_q >> 5;
        op_d   = op_q >> 4;
        if (set_en) begin
            resv_d[set_idx] = 1'b1;
            rd_d[set_idx]   = set_rd;
            op_d[set_idx]   = set_op;
        end
        if (flush) begin
            resv_d = '0;
            rd_d   = '0;
            op_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_q <= '0;
            rd_q   <= '0;
            op_q   <= '0;
        end else begin
            resv_q <= resv_d;
            rd_q   <= rd_d;
            op_q   <= op_d;
        end
    end

    assign wb_valid = resv_q[0];
    assign wb_rd    = rd_q[0];
    assign wb_op    = op_q[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// Float issue scheduler: RAW/WAW scoreboard, iterative-unit interlock and writeback slot reservation.
// Optional macro FPU_ISSUE_SCHED_BYPASS_EN lets a source hazard clear in its writeback cycle.
module fpu_issue_sched
    import fpu_issue_sched_pkg::*;
#(
    parameter int LAT_ADD  = LAT_ADD_DEF,
    parameter int LAT_MUL  = LAT_MUL_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int LAT_SQRT = LAT_SQRT_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    localparam int IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1,
    localparam int CW = $clog2(MAX_LAT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    output logic        fpu_fire,
    output logic [3:0]  fpu_op,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [3:0]  wb_op,
    output logic [31:0] busy_mask,
    output logic        iter_busy
);

    logic [31:0]        busy_q, busy_d;
    logic [CW-1:0]      iter_cnt_q, iter_cnt_d;
    logic [MAX_LAT-1:0] slot_busy;
    logic [IW-1:0]      lat_idx;
    logic               req_iter;
    logic               haz_rs1, haz_rs2;
    int                 lat;

    always_comb begin
        lat      = op_latency(req_op, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT);
        lat_idx  = IW'(lat - 1);
        req_iter = is_iter_op(req_op);
`ifdef FPU_ISSUE_SCHED_BYPASS_EN
        haz_rs1 = busy_q[req_rs1] && !(wb_valid && (wb_rd == req_rs1));
        haz_rs2 = busy_q[req_rs2] && !(wb_valid && (wb_rd == req_rs2));
`else
        haz_rs1 = busy_q[req_rs1];
        haz_rs2 = busy_q[req_rs2];
`endif
        req_ready = !flush && !haz_rs1 && !haz_rs2 && !busy_q[req_rd]
                    && !slot_busy[lat_idx] && !(req_iter && iter_busy);
        fpu_fire  = req_valid && req_ready;
        fpu_op    = fpu_fire ? req_op : 4'd0;
    end

    fpu_wb_resv #(.MAX_LAT(MAX_LAT)) u_resv (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .set_en    (fpu_fire),
        .set_idx   (lat_idx),
        .set_rd    (req_rd),
        .set_op    (req_op),
        .slot_busy (slot_busy),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_op     (wb_op)
    );

    // Clear before set: WAW blocking guarantees the two never hit the same bit
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (fpu_fire) busy_d[req_rd] = 1'b1;
        if (flush) busy_d = '0;

        iter_cnt_d = iter_cnt_q;
        if (flush)
            iter_cnt_d = '0;
        else if (fpu_fire && req_iter)
            iter_cnt_d = CW'(lat - 1);
        else if (iter_cnt_q != '0)
            iter_cnt_d = iter_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            iter_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    assign busy_mask = busy_q;
    assign iter_busy = (iter_cnt_q != '0);

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- Issue scheduler for the shared floating-point datapath (fadd/fsub/fmul/fdiv/fsqrt/itof/floor/fneg/fabs/fslwi).
- Sits between decode and execute. Accepts one float op per cycle and tracks per-op latency.
- Blocks RAW and WAW hazards on the 32 float registers and the non-pipelined div/sqrt unit.
- Guarantees at most one float writeback per cycle by reserving writeback slots.

Parameters:
LAT_ADD, 2, cycles for FADD/FSUB/ITOF/FLOOR (pipelined)
LAT_MUL, 2, cycles for FMUL (pipelined)
LAT_DIV, 4, cycles for FDIV (iterative, non-pipelined)
LAT_SQRT, 4, cycles for FSQRT (shares the iterative unit with FDIV)
MAX_LAT, 8, depth of the writeback reservation vector; every LAT_* must be in 1..MAX_LAT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all in-flight ops
req_valid  in  1  decode presents a float op
req_ready  out  1  scheduler accepts the op this cycle (combinational)
req_op  in  4  FLOAT_* opcode
req_rd  in  5  destination float register
req_rs1  in  5  source 1 float register
req_rs2  in  5  source 2 float register
fpu_fire  out  1  req_valid && req_ready; execute latches operands this cycle
fpu_op  out  4  req_op passed through when fpu_fire, else 0
wb_valid  out  1  a float result is written back this cycle (registered)
wb_rd  out  5  destination of the writeback
wb_op  out  4  opcode of the writeback
busy_mask  out  32  registered pending-write bit per float register
iter_busy  out  1  iterative div/sqrt unit occupied

Behaviour:
- Latency class L from req_op:
  - FADD/FSUB/ITOF/FLOOR = LAT_ADD.
  - FMUL = LAT_MUL.
  - FDIV = LAT_DIV.
  - FSQRT = LAT_SQRT.
  - FNEG/FABS/FSLWI/any other = 1.
- req_ready = !flush && !busy_mask[rs1] && !busy_mask[rs2] && !busy_mask[rd] && !resv[L-1] && !(op is DIV/SQRT && iter_busy).
- Reservation vector resv[MAX_LAT-1:0], with parallel rd/op slot registers:
  - Every edge shifts down one place.
  - On fpu_fire, slot L-1 of the shifted vector is set with req_rd/req_op.
  - wb_valid/wb_rd/wb_op come from slot 0.
- Timing: a fire in cycle t gives wb_valid high for exactly cycle t+L. L=1 means writeback the cycle after fire.
- busy_mask:
  - Bit rd is set at the edge ending the fire cycle.
  - It is cleared at the edge ending its wb_valid cycle.
  - Set and clear of different bits on the same edge both apply.
  - Set and clear of the same bit cannot coincide, because the WAW check blocks it.
- Iterative unit:
  - iter_cnt is loaded with L-1 on a DIV/SQRT fire and decrements to 0.
  - iter_busy = (iter_cnt != 0).
  - A new DIV/SQRT may fire in the same cycle its predecessor writes back.
- Flush: the next edge clears resv, slots, busy_mask and iter_cnt. req_ready is low during flush, and wb_valid is low from the following cycle.
- Reset: every output register is 0 (wb_valid, wb_rd, wb_op, busy_mask, iter_busy). req_ready is 1 once rst deasserts and flush=0.
- Reset asserted mid-operation drops all in-flight ops with no writeback.
- req_valid=0 gives no fire; req_* values are ignored.
- Register f0 gets no special casing.

Optional Feature:
FPU_ISSUE_SCHED_BYPASS_EN
- Defined: a source hazard is ignored when wb_valid && wb_rd == that source, so a dependent op fires in the writeback cycle. Execute supplies the forwarding mux.
- Undefined: sources stall until busy_mask clears, which costs one extra cycle.
- The destination (WAW) check is strict in both cases.

Decomposition:
- Shared package/header: FLOAT_* opcodes (reused), latency-class constants, the MAX_LAT default.
- Natural sub-module: fpu_wb_resv, the reservation shift vector with rd/op slots, parameterised by MAX_LAT.
- Hazard logic and iter_cnt stay in the top module.

Test Plan:
- FADD rd=3 fires at t=10 -> wb_valid=1, wb_rd=3 at t=12 only; busy_mask[3]=1 for t=11..12, then 0.
- FDIV rd=4 at t=0, FDIV rd=5 requested at t=1 -> req_ready=0 for t=1..3, fires t=4, wb rd=5 at t=8.
- FMUL rd=1 at t=0 (wb t=2), FNEG rd=2 requested t=1 -> slot collision, ready=0 at t=1, fires t=2, wb t=3.
- FADD rd=6 at t=0, then FMUL rs1=6 -> without bypass fires t=3; with FPU_ISSUE_SCHED_BYPASS_EN fires t=2.
- Three ops in flight, flush at t=2 -> no wb_valid from t=3, busy_mask=0 at t=3, new op accepted t=3.
- rst pulsed asynchronously mid-FSQRT -> all outputs 0 immediately, iter_busy=0, no writeback emitted.
